// File: rtl/io_channel_unit_pkg.sv
// rtl/io_channel_unit_pkg.sv - shared FSM encodings and defaults for the io channel unit
//
// Purpose : state encodings shared by the INP and OUT handshake FSMs, plus the
//           default data word width used by the top level.
// Ports   : none (package)

package io_channel_unit_pkg;

    // Handshake FSM encodings, shared by the INP and OUT sides.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam int DW_DEFAULT = 16;

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - first-word-fall-through FIFO used for each channel direction
//
// Purpose : DEPTH-entry FIFO with combinational head (FWFT). A push into a full
//           FIFO or a pop from an empty one is ignored. Flushed by reset.
// Ports   : clk, rst_b      clock, async active-low reset
//           push, push_data write request and word
//           pop             remove head word
//           head            current head word (0 while empty)
//           full, empty     occupancy flags (from registered count)

module io_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Fullness is judged on the registered count, so a same-cycle pop never
    // makes room for a push into a full FIFO.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head is forced to zero while empty so stale words never show after a flush.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_channel_unit.sv
// rtl/io_channel_unit.sv - multi-channel buffered INP/OUT unit between the CU and devices
//
// Purpose : bridges the CU's four-phase INP/OUT handshakes to NCH device channels,
//           each with a receive FIFO (device->CU) and a transmit FIFO (CU->device).
// Ports   : clk, rst_b                         clock, async active-low reset
//           inp_req/inp_ch/inp_data/inp_ack     CU input handshake
//           out_req/out_ch/out_data/out_ack     CU output handshake
//           dev_in_data/valid/ready             per-channel device receive side
//           dev_out_data/valid/ready            per-channel device transmit side (FWFT)
//           inp_avail, out_space                per-channel FIFO status
//           err                                 sticky: request named channel >= NCH

module io_channel_unit
    import io_channel_unit_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 4,
    parameter int NCH   = 2,
    parameter int CHW   = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              inp_req,
    input  logic [CHW-1:0]    inp_ch,
    output logic [DW-1:0]     inp_data,
    output logic              inp_ack,
    input  logic              out_req,
    input  logic [CHW-1:0]    out_ch,
    input  logic [DW-1:0]     out_data,
    output logic              out_ack,
    input  logic [NCH*DW-1:0] dev_in_data,
    input  logic [NCH-1:0]    dev_in_valid,
    output logic [NCH-1:0]    dev_in_ready,
    output logic [NCH*DW-1:0] dev_out_data,
    output logic [NCH-1:0]    dev_out_valid,
    input  logic [NCH-1:0]    dev_out_ready,
    output logic [NCH-1:0]    inp_avail,
    output logic [NCH-1:0]    out_space,
    output logic              err
);

    logic [1:0]    inp_state;
    logic [1:0]    out_state;

    logic [DW-1:0] rx_head [NCH];
    logic [NCH-1:0] rx_full;
    logic [NCH-1:0] rx_empty;
    logic [NCH-1:0] rx_pop;
    logic [NCH-1:0] tx_full;
    logic [NCH-1:0] tx_empty;
    logic [NCH-1:0] tx_push;

    logic          inp_ch_ok;
    logic          out_ch_ok;
    logic [DW-1:0] rx_sel_head;
    logic          rx_sel_avail;
    logic          tx_sel_space;
    logic          inp_take;
    logic          out_give;

    // ------------------------------------------------------------------
    // Per-channel FIFOs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
            .clk       (clk),
            .rst_b     (rst_b),
            .push      (dev_in_valid[i]),
            .push_data (dev_in_data[i*DW +: DW]),
            .pop       (rx_pop[i]),
            .head      (rx_head[i]),
            .full      (rx_full[i]),
            .empty     (rx_empty[i])
        );

        io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
            .clk       (clk),
            .rst_b     (rst_b),
            .push      (tx_push[i]),
            .push_data (out_data),
            .pop       (dev_out_ready[i]),
            .head      (dev_out_data[i*DW +: DW]),
            .full      (tx_full[i]),
            .empty     (tx_empty[i])
        );
    end

    assign dev_in_ready  = ~rx_full;
    assign inp_avail     = ~rx_empty;
    assign dev_out_valid = ~tx_empty;
    assign out_space     = ~tx_full;

    assign inp_ack = (inp_state == ST_ACK);
    assign out_ack = (out_state == ST_ACK);

    assign inp_ch_ok = (32'(inp_ch) < NCH);
    assign out_ch_ok = (32'(out_ch) < NCH);

    // ------------------------------------------------------------------
    // Channel selection and FIFO strobes. IDLE needs a live request; WAIT
    // only exists for a valid channel whose request is still held.
    // ------------------------------------------------------------------
    always_comb begin
        rx_sel_head  = '0;
        rx_sel_avail = 1'b0;
        tx_sel_space = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (32'(inp_ch) == i) begin
                rx_sel_head  = rx_head[i];
                rx_sel_avail = ~rx_empty[i];
            end
            if (32'(out_ch) == i) begin
                tx_sel_space = ~tx_full[i];
            end
        end
    end

    assign inp_take = inp_ch_ok && rx_sel_avail &&
                      (((inp_state == ST_IDLE) && inp_req) || (inp_state == ST_WAIT));
    assign out_give = out_ch_ok && tx_sel_space &&
                      (((out_state == ST_IDLE) && out_req) || (out_state == ST_WAIT));

    always_comb begin
        rx_pop  = '0;
        tx_push = '0;
        for (int i = 0; i < NCH; i++) begin
            rx_pop[i]  = inp_take && (32'(inp_ch) == i);
            tx_push[i] = out_give && (32'(out_ch) == i);
        end
    end

    // ------------------------------------------------------------------
    // INP handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            inp_state <= ST_IDLE;
            inp_data  <= '0;
        end else begin
            case (inp_state)
                ST_IDLE: begin
                    if (inp_req) begin
                        if (!inp_ch_ok) begin
                            inp_data  <= '0;
                            inp_state <= ST_ACK;
                        end else if (inp_take) begin
                            inp_data  <= rx_sel_head;
                            inp_state <= ST_ACK;
                        end else begin
                            inp_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (inp_take) begin
                        inp_data  <= rx_sel_head;
                        inp_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!inp_req) begin
                        inp_state <= ST_IDLE;
                    end
                end
                default: inp_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // OUT handshake FSM (the push itself happens through tx_push)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_state <= ST_IDLE;
        end else begin
            case (out_state)
                ST_IDLE: begin
                    if (out_req) begin
                        if (!out_ch_ok || out_give) begin
                            out_state <= ST_ACK;
                        end else begin
                            out_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (out_give) begin
                        out_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!out_req) begin
                        out_state <= ST_IDLE;
                    end
                end
                default: out_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error; only reset clears it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err <= 1'b0;
        end else if (((inp_state == ST_IDLE) && inp_req && !inp_ch_ok) ||
                     ((out_state == ST_IDLE) && out_req && !out_ch_ok)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_channel_unit.sv
// tb/tb_io_channel_unit.sv - directed self-checking bench for io_channel_unit

module tb_io_channel_unit;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int NCH   = 2;
    localparam int CHW   = 2;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              inp_req;
    logic [CHW-1:0]    inp_ch;
    logic [DW-1:0]     inp_data;
    logic              inp_ack;
    logic              out_req;
    logic [CHW-1:0]    out_ch;
    logic [DW-1:0]     out_data;
    logic              out_ack;
    logic [NCH*DW-1:0] dev_in_data;
    logic [NCH-1:0]    dev_in_valid;
    logic [NCH-1:0]    dev_in_ready;
    logic [NCH*DW-1:0] dev_out_data;
    logic [NCH-1:0]    dev_out_valid;
    logic [NCH-1:0]    dev_out_ready;
    logic [NCH-1:0]    inp_avail;
    logic [NCH-1:0]    out_space;
    logic              err;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    io_channel_unit #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH), .CHW(CHW)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .inp_req       (inp_req),
        .inp_ch        (inp_ch),
        .inp_data      (inp_data),
        .inp_ack       (inp_ack),
        .out_req       (out_req),
        .out_ch        (out_ch),
        .out_data      (out_data),
        .out_ack       (out_ack),
        .dev_in_data   (dev_in_data),
        .dev_in_valid  (dev_in_valid),
        .dev_in_ready  (dev_in_ready),
        .dev_out_data  (dev_out_data),
        .dev_out_valid (dev_out_valid),
        .dev_out_ready (dev_out_ready),
        .inp_avail     (inp_avail),
        .out_space     (out_space),
        .err           (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b         = 1'b0;
        inp_req       = 1'b0;
        inp_ch        = '0;
        out_req       = 1'b0;
        out_ch        = '0;
        out_data      = '0;
        dev_in_data   = '0;
        dev_in_valid  = '0;
        dev_out_ready = '0;
        tick();
        tick();

        // Reset values
        chk("rst_inp_ack",       32'(inp_ack), 32'd0);
        chk("rst_out_ack",       32'(out_ack), 32'd0);
        chk("rst_inp_data",      32'(inp_data), 32'd0);
        chk("rst_err",           32'(err), 32'd0);
        chk("rst_dev_in_ready",  32'(dev_in_ready), 32'h3);
        chk("rst_dev_out_valid", 32'(dev_out_valid), 32'h0);
        chk("rst_dev_out_data",  32'(dev_out_data), 32'h0);
        chk("rst_inp_avail",     32'(inp_avail), 32'h0);
        chk("rst_out_space",     32'(out_space), 32'h3);
        rst_b = 1'b1;
        tick();

        // Device ch1 pushes 0x1234, CU reads it
        dev_in_data  = {16'h1234, 16'h0000};
        dev_in_valid = 2'b10;
        tick();
        dev_in_valid = 2'b00;
        chk("push1_inp_avail", 32'(inp_avail), 32'h2);
        inp_req = 1'b1;
        inp_ch  = 2'd1;
        tick();
        chk("inp1_ack",       32'(inp_ack), 32'd1);
        chk("inp1_data",      32'(inp_data), 32'h1234);
        chk("inp1_avail",     32'(inp_avail), 32'h0);
        inp_req = 1'b0;
        tick();
        chk("inp1_ack_fall",  32'(inp_ack), 32'd0);

        // INP on empty ch0 waits for the device
        inp_req = 1'b1;
        inp_ch  = 2'd0;
        tick();
        chk("inp0_wait_a", 32'(inp_ack), 32'd0);
        tick();
        tick();
        chk("inp0_wait_b", 32'(inp_ack), 32'd0);
        dev_in_data  = {16'h0000, 16'h00AA};
        dev_in_valid = 2'b01;
        tick();
        dev_in_valid = 2'b00;
        chk("inp0_push_noack", 32'(inp_ack), 32'd0);
        chk("inp0_push_avail", 32'(inp_avail), 32'h1);
        tick();
        chk("inp0_ack",   32'(inp_ack), 32'd1);
        chk("inp0_data",  32'(inp_data), 32'h00AA);
        chk("inp0_avail", 32'(inp_avail), 32'h0);
        inp_req = 1'b0;
        tick();
        chk("inp0_ack_fall", 32'(inp_ack), 32'd0);

        // OUT 1..4 into ch0 with the device stalled
        for (int v = 1; v <= 4; v++) begin
            out_req  = 1'b1;
            out_ch   = 2'd0;
            out_data = 16'(v);
            tick();
            chk($sformatf("out%0d_ack", v), 32'(out_ack), 32'd1);
            out_req = 1'b0;
            tick();
            chk($sformatf("out%0d_ack_fall", v), 32'(out_ack), 32'd0);
        end
        chk("tx_full_space", 32'(out_space), 32'h2);
        chk("tx_head_1",     32'(dev_out_data[15:0]), 32'h0001);
        chk("tx_valid",      32'(dev_out_valid), 32'h1);

        // OUT 5 blocks until one word drains
        out_req  = 1'b1;
        out_data = 16'd5;
        tick();
        chk("out5_block_a", 32'(out_ack), 32'd0);
        tick();
        chk("out5_block_b", 32'(out_ack), 32'd0);
        dev_out_ready = 2'b01;
        tick();
        dev_out_ready = 2'b00;
        chk("out5_pop_noack", 32'(out_ack), 32'd0);
        chk("tx_head_2",      32'(dev_out_data[15:0]), 32'h0002);
        tick();
        chk("out5_ack", 32'(out_ack), 32'd1);
        out_req = 1'b0;
        tick();
        chk("out5_ack_fall", 32'(out_ack), 32'd0);

        dev_out_ready = 2'b01;
        for (int v = 2; v <= 5; v++) begin
            chk($sformatf("drain%0d_valid", v), 32'(dev_out_valid[0]), 32'd1);
            chk($sformatf("drain%0d_data", v),  32'(dev_out_data[15:0]), 32'(v));
            tick();
        end
        dev_out_ready = 2'b00;
        chk("drain_empty", 32'(dev_out_valid), 32'h0);
        chk("drain_space", 32'(out_space), 32'h3);

        // Invalid INP channel
        inp_req = 1'b1;
        inp_ch  = 2'd3;
        tick();
        chk("inv_inp_ack",  32'(inp_ack), 32'd1);
        chk("inv_inp_data", 32'(inp_data), 32'h0);
        chk("inv_inp_err",  32'(err), 32'd1);
        inp_req = 1'b0;
        tick();
        chk("inv_inp_ack_fall", 32'(inp_ack), 32'd0);

        // Valid OUT on ch1 afterwards; err stays set
        out_req  = 1'b1;
        out_ch   = 2'd1;
        out_data = 16'hBEEF;
        tick();
        chk("ch1_out_ack",   32'(out_ack), 32'd1);
        chk("ch1_err_stick", 32'(err), 32'd1);
        chk("ch1_valid",     32'(dev_out_valid), 32'h2);
        chk("ch1_head",      32'(dev_out_data[31:16]), 32'hBEEF);
        out_req = 1'b0;
        tick();

        // Second word on ch1, then async reset while out_ack is high
        out_req  = 1'b1;
        out_data = 16'h5555;
        tick();
        chk("pre_rst_ack",   32'(out_ack), 32'd1);
        chk("pre_rst_space", 32'(out_space), 32'h3);
        #2;
        rst_b   = 1'b0;
        out_req = 1'b0;
        #1;
        chk("async_rst_ack",   32'(out_ack), 32'd0);
        chk("async_rst_space", 32'(out_space), 32'h3);
        chk("async_rst_valid", 32'(dev_out_valid), 32'h0);
        chk("async_rst_err",   32'(err), 32'd0);
        tick();
        rst_b = 1'b1;
        tick();

        // Invalid OUT channel: ack, err, nothing pushed
        out_req  = 1'b1;
        out_ch   = 2'd2;
        out_data = 16'h7777;
        tick();
        chk("inv_out_ack",   32'(out_ack), 32'd1);
        chk("inv_out_err",   32'(err), 32'd1);
        chk("inv_out_valid", 32'(dev_out_valid), 32'h0);
        out_req = 1'b0;
        tick();
        chk("inv_out_ack_fall", 32'(out_ack), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
